// File: rtl/cs3421_rrk_processor_pkg.sv
`default_nettype none
// ============================================================================
// Module : cs3421_rrk_processor_pkg
// Brief  : Shared widths, instruction field positions and opcode constants.
// Rev    : 1.0  initial release
// ============================================================================
package cs3421_rrk_processor_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [5:0]        OP_JAL = 6'b000011;
    localparam logic [ADDR_W-1:0] REG_RA = 5'd31;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int IMM_HI   = 15;
    localparam int JIMM_HI  = 25;

endpackage
`default_nettype wire

// File: rtl/cs3421_rrk_processor_register_file.sv
`default_nettype none
// ============================================================================
// Module : cs3421_rrk_processor_register_file
// Brief  : 32x32 register file, two async read ports, one sync write port.
// Rev    : 1.0  initial release
// ============================================================================
module cs3421_rrk_processor_register_file
    import cs3421_rrk_processor_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Reset is tested first so an unknown write enable cannot disturb the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WE3 && (A3 != '0)) begin
            r_regs[A3] <= WD3;
        end
    end

    assign RD1 = (A1 == '0) ? '0 : r_regs[A1];
    assign RD2 = (A2 == '0) ? '0 : r_regs[A2];

endmodule
`default_nettype wire

// File: rtl/cs3421_rrk_processor.sv
`default_nettype none
// ============================================================================
// Module : cs3421_rrk_processor
// Brief  : Decode stage: instruction field slicing plus register file access.
// Rev    : 1.0  initial release
// ============================================================================
module cs3421_rrk_processor
    import cs3421_rrk_processor_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instruction,
    input  logic [DATA_W-1:0] PC_Plus4,
    input  logic [DATA_W-1:0] Result,
    input  logic              Reg_Dst,
    input  logic              Reg_Write,
    output logic [5:0]        Instr_Op_Code,
    output logic [ADDR_W-1:0] Instr_A1_Adr,
    output logic [ADDR_W-1:0] Instr_A2_Adr,
    output logic [ADDR_W-1:0] Instr_A3_Adr,
    output logic [5:0]        Instr_Funct_Code,
    output logic [15:0]       Instr_Imm_Value,
    output logic [25:0]       Instr_Jump_Imm,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    logic              w_is_jal;
    logic [ADDR_W-1:0] w_wa3;
    logic [DATA_W-1:0] w_wd3;

    assign Instr_Op_Code    = Instruction[OP_HI:OP_LO];
    assign Instr_A1_Adr     = Instruction[RS_HI:RS_LO];
    assign Instr_A2_Adr     = Instruction[RT_HI:RT_LO];
    assign Instr_A3_Adr     = Instruction[RD_HI:RD_LO];
    assign Instr_Funct_Code = Instruction[FUNCT_HI:0];
    assign Instr_Imm_Value  = Instruction[IMM_HI:0];
    assign Instr_Jump_Imm   = Instruction[JIMM_HI:0];

    // JAL overrides both muxes: link address goes to $ra.
    assign w_is_jal = (Instr_Op_Code == OP_JAL);
    assign w_wa3    = w_is_jal ? REG_RA : (Reg_Dst ? Instr_A3_Adr : Instr_A2_Adr);
    assign w_wd3    = w_is_jal ? PC_Plus4 : Result;

    cs3421_rrk_processor_register_file u_register_file (
        .clk   (clk),
        .reset (reset),
        .WE3   (Reg_Write),
        .A1    (Instr_A1_Adr),
        .A2    (Instr_A2_Adr),
        .A3    (w_wa3),
        .WD3   (w_wd3),
        .RD1   (RD1),
        .RD2   (RD2)
    );

endmodule
`default_nettype wire

// File: tb/tb_cs3421_rrk_processor.sv
`default_nettype none
// ============================================================================
// Module : tb_cs3421_rrk_processor
// Brief  : Vector table, hand sequences and randomized model check.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cs3421_rrk_processor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction;
    logic [31:0] PC_Plus4;
    logic [31:0] Result;
    logic        Reg_Dst;
    logic        Reg_Write;
    logic [5:0]  Instr_Op_Code;
    logic [4:0]  Instr_A1_Adr;
    logic [4:0]  Instr_A2_Adr;
    logic [4:0]  Instr_A3_Adr;
    logic [5:0]  Instr_Funct_Code;
    logic [15:0] Instr_Imm_Value;
    logic [25:0] Instr_Jump_Imm;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int checks = 0;
    int errors = 0;

    cs3421_rrk_processor dut (
        .clk              (clk),
        .reset            (reset),
        .Instruction      (Instruction),
        .PC_Plus4         (PC_Plus4),
        .Result           (Result),
        .Reg_Dst          (Reg_Dst),
        .Reg_Write        (Reg_Write),
        .Instr_Op_Code    (Instr_Op_Code),
        .Instr_A1_Adr     (Instr_A1_Adr),
        .Instr_A2_Adr     (Instr_A2_Adr),
        .Instr_A3_Adr     (Instr_A3_Adr),
        .Instr_Funct_Code (Instr_Funct_Code),
        .Instr_Imm_Value  (Instr_Imm_Value),
        .Instr_Jump_Imm   (Instr_Jump_Imm),
        .RD1              (RD1),
        .RD2              (RD2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] res;
        logic        dst;
        logic        we;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
    } vec_t;

    vec_t vecs [13];
    logic [31:0] mdl [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Field expectations by arithmetic on the instruction word.
    task automatic chk_fields(input logic [31:0] ins);
        chk("opcode", {26'd0, Instr_Op_Code},    ins / 32'h0400_0000);
        chk("rs",     {27'd0, Instr_A1_Adr},     (ins / 32'h0020_0000) % 32);
        chk("rt",     {27'd0, Instr_A2_Adr},     (ins / 32'h0001_0000) % 32);
        chk("rd",     {27'd0, Instr_A3_Adr},     (ins / 32'h0000_0800) % 32);
        chk("funct",  {26'd0, Instr_Funct_Code}, ins % 64);
        chk("imm",    {16'd0, Instr_Imm_Value},  ins % 65536);
        chk("jimm",   {6'd0, Instr_Jump_Imm},    ins % 32'h0400_0000);
    endtask

    task automatic drive(input logic rst, input logic [31:0] ins, input logic [31:0] pc4,
                         input logic [31:0] res, input logic dst, input logic we);
        @(posedge clk);
        #1;
        reset = rst; Instruction = ins; PC_Plus4 = pc4;
        Result = res; Reg_Dst = dst; Reg_Write = we;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ins;
        logic [4:0]  wa;
        logic        r_rst, r_dst, r_we;
        logic [31:0] r_pc, r_res;

        vecs[0]  = '{1'b0, 32'h012A4020, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 32'h012A4020, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 32'h01004820, 32'h0, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0, 32'h20090005, 32'h0, 32'h5,        1'b0, 1'b1, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 32'h01280000, 32'h0, 32'h0,        1'b0, 1'b0, 32'h5,        32'hDEADBEEF};
        vecs[5]  = '{1'b0, 32'h00000020, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0,        32'h0};
        vecs[6]  = '{1'b0, 32'h00000000, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, 32'h0C000010, 32'h00400008, 32'h1234, 1'b0, 1'b1, 32'h0,     32'h0};
        vecs[8]  = '{1'b0, 32'h03E80000, 32'h0, 32'h0,        1'b0, 1'b0, 32'h00400008, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 32'h03E84020, 32'h0, 32'h55,       1'b1, 1'b0, 32'h00400008, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 32'h03E84020, 32'h0, 32'h0,        1'b0, 1'b0, 32'h00400008, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 32'h03E84020, 32'h0, 32'h77,       1'b1, 1'b1, 32'h00400008, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 32'h03E84020, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};

        reset = 1'b1; Instruction = 32'h012A4020; PC_Plus4 = '0;
        Result = '0; Reg_Dst = 1'b0; Reg_Write = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].instr, vecs[i].pc4, vecs[i].res, vecs[i].dst, vecs[i].we);
            chk($sformatf("vec%0d_rd1", i), RD1, vecs[i].exp_rd1);
            chk($sformatf("vec%0d_rd2", i), RD2, vecs[i].exp_rd2);
            chk_fields(vecs[i].instr);
        end

        // Load reg8, then reset with an unknown write enable aimed at reg8.
        drive(1'b0, 32'h012A4020, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1);
        drive(1'b0, 32'h01000000, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("preload_reg8", RD1, 32'hCAFEF00D);
        drive(1'b1, 32'h012A4020, 32'h0, 32'h99, 1'b1, 1'bx);
        drive(1'b0, 32'h01000000, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset_x_we_reg8", RD1, 32'h0);

        for (int i = 0; i < 32; i++) mdl[i] = '0;

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(3) == 0) ins[31:26] = 6'b000011;
            r_rst = ($urandom_range(24) == 0);
            r_dst = $urandom_range(1);
            r_we  = $urandom_range(1);
            r_pc  = $urandom;
            r_res = $urandom;
            drive(r_rst, ins, r_pc, r_res, r_dst, r_we);
            chk("rand_rd1", RD1, mdl[(ins >> 21) % 32]);
            chk("rand_rd2", RD2, mdl[(ins >> 16) % 32]);
            if (n % 16 == 0) chk_fields(ins);
            if (r_rst) begin
                for (int i = 0; i < 32; i++) mdl[i] = '0;
            end else if (r_we) begin
                if ((ins >> 26) == 3) wa = 5'd31;
                else if (r_dst)       wa = 5'((ins >> 11) % 32);
                else                  wa = 5'((ins >> 16) % 32);
                if (wa != 0) mdl[wa] = ((ins >> 26) == 3) ? r_pc : r_res;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cs3421_rrk_processor.md
# cs3421_rrk_processor

Decode-and-register-file stage of the CS3421 single-cycle MIPS-style processor. It slices a 32-bit instruction into its fields and reads two source registers from a 32×32 register file. It also writes a supplied result back into the register file on the clock edge. Control signals and the write-back value arrive as inputs from the surrounding datapath (control unit, ALU/memory mux).

## Interface
- No parameters; widths fixed: data 32, register address 5, 32 registers.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears register file.
- Instruction  input  32  current instruction word.
- PC_Plus4  input  32  address of next sequential instruction; link value for JAL.
- Result  input  32  write-back data (ALU or memory result).
- Reg_Dst  input  1  write-address select: 1 = rd (Instruction[15:11]), 0 = rt (Instruction[20:16]).
- Reg_Write  input  1  register-file write enable.
- Instr_Op_Code  output  6  Instruction[31:26].
- Instr_A1_Adr  output  5  Instruction[25:21] (rs).
- Instr_A2_Adr  output  5  Instruction[20:16] (rt).
- Instr_A3_Adr  output  5  Instruction[15:11] (rd).
- Instr_Funct_Code  output  6  Instruction[5:0].
- Instr_Imm_Value  output  16  Instruction[15:0].
- Instr_Jump_Imm  output  26  Instruction[25:0].
- RD1  output  32  register[rs].
- RD2  output  32  register[rt].

## Operation
- Field outputs: pure combinational slices of Instruction, no registering.
- Reads: RD1 = reg[Instruction[25:21]], RD2 = reg[Instruction[20:16]], combinational (asynchronous read).
- Register 0 always reads 0; writes to it are discarded.
- Write address WA3: opcode 6'b000011 (JAL) forces 31; else Reg_Dst ? rd : rt.
- Write data WD3: JAL → PC_Plus4; else Result.
- Write: on rising clk with Reg_Write=1 and reset=0, reg[WA3] ← WD3 (skipped if WA3 = 0).
- Reset: on rising clk with reset=1, all 32 registers ← 0; reset wins over a simultaneous write.
- No internal PC, ALU or memory; PC_Plus4 is used only as the JAL link value.

## Timing
- Combinational outputs settle within the same cycle after Instruction changes.
- Write latency 1 edge: a value written at edge N is visible on RD1/RD2 after edge N. A same-cycle read of the address being written returns the old value (no bypass).
- Read and write of the same register in one cycle: read shows pre-edge contents; post-edge shows new value.
- After reset deasserts, all RD1/RD2 read 0 until written.
- X on Reg_Write must not corrupt registers when reset=1.
- Bench convention: inputs change 1 time unit after rising edge; outputs sampled at falling edge.

## Structure
- Shared package: opcode constant OP_JAL = 6'b000011, link register index REG_RA = 31, field bit-position constants, data/address width constants.
- One sub-module: register_file (clk, reset, WE3, A1, A2, A3, WD3 → RD1, RD2), holding the 32×32 array, the zero-register rule and the reset clear.
- Top level holds field slicing, write-address mux and write-data mux.

## Test plan
- Reset then read: reset=1 one edge, Instruction=0x012A4020 (add $8,$9,$10) → RD1=0, RD2=0, Instr_Op_Code=0, Instr_A1_Adr=9, Instr_A2_Adr=10, Instr_A3_Adr=8, Instr_Funct_Code=0x20.
- R-type write: Reg_Dst=1, Reg_Write=1, Result=0xDEADBEEF, Instruction rd=8; next cycle Instruction rs=8 → RD1=0xDEADBEEF.
- I-type write: Instruction=0x2009_0005 (addi $9,$0,5), Reg_Dst=0, Reg_Write=1, Result=5 → reg9=5. Instr_Imm_Value=0x0005 and Instr_A2_Adr=9 on the same cycle.
- Zero register: Reg_Write=1, Reg_Dst=1, rd=0, Result=0xFFFFFFFF → reading rs=0 gives RD1=0.
- JAL link: Instruction=0x0C000010, PC_Plus4=0x00400008, Reg_Write=1, Result=0x1234 → reg31=0x00400008; Instr_Jump_Imm=0x0000010.
- Write disabled / reset priority: Reg_Write=0 leaves reg8 unchanged. Reset=1 together with Reg_Write=1 to reg8 → reg8 reads 0.
